// File: rtl/tdm_mux_4to1_pkg.sv
// Shared state encodings and slot codes for the TDM mux; the slot codes also
// appear on the demux side, so they must stay numerically fixed.
package tdm_mux_4to1_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  localparam int unsigned DWELL_CNT_W = 8;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    if (m[0]) return SLOT0;
    if (m[1]) return SLOT1;
    if (m[2]) return SLOT2;
    if (m[3]) return SLOT3;
    return SLOT0;
  endfunction

endpackage

// File: rtl/tdm_next_slot.sv
// Combinational slot search: lowest enabled slot, next enabled slot above cur,
// and whether cur is the last enabled slot of the frame.
module tdm_next_slot
  import tdm_mux_4to1_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  output logic [1:0] first,
  output logic [1:0] next,
  output logic       last
);

  always_comb begin
    first = lowest_set(mask);
    next  = cur;
    last  = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (2'(i) > cur)) begin
        next = 2'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_4to1.sv
// Four-channel TDM transmitter: snapshots d0..d3 per frame and serialises the
// enabled slots on y with the slot index on {s1,s0}.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no frame in flight; launch when en=1 and ch_mask != 0
//   ST_SLOT | holding slot slot_q on y; advance when the dwell counter hits 0
module tdm_mux_4to1
  import tdm_mux_4to1_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       ch_mask,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  output logic             y,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned DW_EFF = (DWELL == 0) ? 1 : DWELL;
  localparam logic [DWELL_CNT_W-1:0] DWELL_LOAD = DWELL_CNT_W'(DW_EFF - 1);

  state_e                 state_q, state_d;
  logic [3:0]             snap_q, snap_d, mask_q, mask_d;
  logic [1:0]             slot_q, slot_d, sel_q, sel_d;
  logic [DWELL_CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   y_q, y_d, valid_q, valid_d, fs_q, fs_d;

  logic [3:0] ns_mask;
  logic [1:0] ns_first, ns_next;
  logic       ns_last, tc, frame_end, launch;

  // In IDLE the search looks at the live mask to pick the launch slot;
  // in SLOT it walks the captured mask.
  assign ns_mask = (state_q == ST_SLOT) ? mask_q : ch_mask;

  tdm_next_slot u_next_slot (
    .mask  (ns_mask),
    .cur   (slot_q),
    .first (ns_first),
    .next  (ns_next),
    .last  (ns_last)
  );

  assign tc        = (dwell_q == '0);
  assign frame_end = (state_q == ST_SLOT) && tc && ns_last;
  assign launch    = en && (ch_mask != 4'b0000) && ((state_q == ST_IDLE) || frame_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_SLOT;
      ST_SLOT: if (frame_end && !launch) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output comb: computes next frame registers and the registered outputs.
  always_comb begin
    snap_d  = snap_q;
    mask_d  = mask_q;
    slot_d  = slot_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    if (launch) begin
      snap_d  = {d3, d2, d1, d0};
      mask_d  = ch_mask;
      slot_d  = (state_q == ST_IDLE) ? ns_first : lowest_set(ch_mask);
      dwell_d = DWELL_LOAD;
      cnt_d   = cnt_q + 1'b1;
    end else if (state_q == ST_SLOT) begin
      if (tc) begin
        slot_d  = ns_next;
        dwell_d = DWELL_LOAD;
      end else begin
        dwell_d = dwell_q - 1'b1;
      end
    end
    valid_d = (state_d == ST_SLOT);
    y_d     = valid_d & snap_d[slot_d];
    sel_d   = valid_d ? slot_d : SLOT0;
    fs_d    = launch;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      mask_q  <= '0;
      slot_q  <= SLOT0;
      dwell_q <= '0;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      sel_q   <= SLOT0;
    end else begin
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      sel_q   <= sel_d;
    end
  end

  assign y           = y_q;
  assign s1          = sel_q[1];
  assign s0          = sel_q[0];
  assign valid       = valid_q;
  assign frame_start = fs_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_mux_4to1.sv
// Bench for tdm_mux_4to1: two instances (DWELL=4/CNT_W=8 and DWELL=2/CNT_W=2)
// with a per-instance beat queue filled at frame boundaries.
module tb_tdm_mux_4to1;

  typedef struct packed {
    logic       y;
    logic [1:0] slot;
    logic       fs;
    logic [7:0] cnt;
  } beat_t;

  typedef struct {
    int         sel;
    logic [3:0] mask;
    logic [3:0] d;
    int         len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] en_v;
  logic [3:0] mask_v [2];
  logic [3:0] d_v    [2];
  logic [1:0] y_v, s1_v, s0_v, vld_v, fs_v;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_v  [2];

  beat_t exp_q [2][$];
  int    ref_cnt [2];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign cnt_v[0] = cnt_a;
  assign cnt_v[1] = {6'd0, cnt_b};

  tdm_mux_4to1 #(.DWELL(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .ch_mask(mask_v[0]),
    .d0(d_v[0][0]), .d1(d_v[0][1]), .d2(d_v[0][2]), .d3(d_v[0][3]),
    .y(y_v[0]), .s1(s1_v[0]), .s0(s0_v[0]), .valid(vld_v[0]),
    .frame_start(fs_v[0]), .frame_cnt(cnt_a)
  );

  tdm_mux_4to1 #(.DWELL(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .ch_mask(mask_v[1]),
    .d0(d_v[1][0]), .d1(d_v[1][1]), .d2(d_v[1][2]), .d3(d_v[1][3]),
    .y(y_v[1]), .s1(s1_v[1]), .s0(s0_v[1]), .valid(vld_v[1]),
    .frame_start(fs_v[1]), .frame_cnt(cnt_b)
  );

  function automatic int dwell_of(input int s);
    return (s == 0) ? 4 : 2;
  endfunction

  function automatic int cnt_wrap(input int s);
    return (s == 0) ? 255 : 3;
  endfunction

  task automatic check(input string name, input int s, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, s, act, exp, $time);
    end
  endtask

  // Frame boundary = no beats outstanding; a launch there pushes the whole frame.
  task automatic producer(input int s);
    bit first;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q[s].delete();
        ref_cnt[s] = 0;
      end else if (exp_q[s].size() == 0 && en_v[s] && mask_v[s] != 4'b0000) begin
        ref_cnt[s] = (ref_cnt[s] + 1) & cnt_wrap(s);
        first = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (mask_v[s][i]) begin
            for (int k = 0; k < dwell_of(s); k++) begin
              exp_q[s].push_back('{y: d_v[s][i], slot: 2'(i), fs: first, cnt: 8'(ref_cnt[s])});
              first = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic monitor(input int s);
    beat_t b;
    forever begin
      @(negedge clk);
      if (exp_q[s].size() == 0) begin
        check("idle_out", s, {11'd0, vld_v[s], y_v[s], s1_v[s], s0_v[s], fs_v[s]}, 16'd0);
      end else begin
        b = exp_q[s].pop_front();
        check("beat", s, {3'd0, vld_v[s], y_v[s], s1_v[s], s0_v[s], fs_v[s], cnt_v[s]},
              {3'd0, 1'b1, b.y, b.slot, b.fs, b.cnt});
      end
    end
  endtask

  task automatic drive(input int s, input logic e, input logic [3:0] m, input logic [3:0] d);
    en_v[s]   = e;
    mask_v[s] = m;
    d_v[s]    = d;
  endtask

  task automatic run_frame(input int s, input logic [3:0] m, input logic [3:0] d, input int len);
    int n;
    @(posedge clk); #2;
    drive(s, 1'b1, m, d);
    @(posedge clk); #2;
    en_v[s] = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (vld_v[s]) n++;
      else if (n > 0) break;
    end
    check("frame_len", s, 16'(n), 16'(len));
  endtask

  vec_t tbl [7];
  int   fs_seen, fs_t0, fs_t1;
  logic [7:0] wrap_got [5];
  logic [7:0] wrap_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{0, 4'b1111, 4'b1011, 16};
    tbl[1] = '{0, 4'b1010, 4'b0101, 8};
    tbl[2] = '{0, 4'b0001, 4'b0001, 4};
    tbl[3] = '{0, 4'b1000, 4'b1000, 4};
    tbl[4] = '{0, 4'b0110, 4'b0110, 8};
    tbl[5] = '{1, 4'b1010, 4'b1010, 4};
    tbl[6] = '{1, 4'b1111, 4'b0110, 8};
    wrap_exp = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) drive(s, 1'b0, 4'b0000, 4'b0000);
    fork
      producer(0); producer(1); monitor(0); monitor(1);
    join_none

    repeat (3) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      check("reset_out", s, {11'd0, vld_v[s], y_v[s], s1_v[s], s0_v[s], fs_v[s]}, 16'd0);
      check("reset_cnt", s, {8'd0, cnt_v[s]}, 16'd0);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) run_frame(tbl[v].sel, tbl[v].mask, tbl[v].d, tbl[v].len);

    // en=1 with an all-zero mask must not launch.
    @(posedge clk); #2;
    drive(1, 1'b1, 4'b0000, 4'b1111);
    repeat (8) @(posedge clk);
    #2;
    check("mask0_valid", 1, {15'd0, vld_v[1]}, 16'd0);
    check("mask0_cnt", 1, {8'd0, cnt_v[1]}, 16'd2);
    en_v[1] = 1'b0;

    // Back-to-back frames, mid-frame d0 change, en dropped in slot 1 of frame 2.
    @(posedge clk); #2;
    drive(0, 1'b1, 4'b1111, 4'b0000);
    fs_seen = 0; fs_t0 = 0; fs_t1 = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #2;
      if (fs_v[0]) begin
        fs_seen++;
        if (fs_seen == 1) fs_t0 = c;
        if (fs_seen == 2) fs_t1 = c;
      end
      if (c == 2)  d_v[0] = 4'b0001;
      if (c == 22) en_v[0] = 1'b0;
      if (c == 32) check("last_slot_live", 0, {14'd0, vld_v[0], s1_v[0]}, 16'd3);
      if (c == 40) check("idle_after_drop", 0, {15'd0, vld_v[0]}, 16'd0);
    end
    check("b2b_fs_count", 0, 16'(fs_seen), 16'd2);
    check("b2b_fs_period", 0, 16'(fs_t1 - fs_t0), 16'd16);

    // Counter wrap on the CNT_W=2 instance from a fresh reset.
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("wrap_reset_cnt", 1, {8'd0, cnt_v[1]}, 16'd0);
    rst_n = 1'b1;
    drive(1, 1'b1, 4'b0001, 4'b0001);
    fs_seen = 0;
    for (int c = 0; c < 40 && fs_seen < 5; c++) begin
      @(posedge clk); #2;
      if (fs_v[1]) begin
        wrap_got[fs_seen] = cnt_v[1];
        fs_seen++;
      end
    end
    en_v[1] = 1'b0;
    check("wrap_fs_count", 1, 16'(fs_seen), 16'd5);
    for (int i = 0; i < 5; i++) check($sformatf("wrap_cnt%0d", i), 1, {8'd0, wrap_got[i]}, {8'd0, wrap_exp[i]});
    repeat (4) @(posedge clk);

    // Asynchronous reset between clock edges during slot 2.
    @(posedge clk); #2;
    drive(0, 1'b1, 4'b1111, 4'b1111);
    @(posedge clk); #2;
    en_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    check("pre_reset_slot", 0, {14'd0, s1_v[0], s0_v[0]}, 16'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 0, {11'd0, vld_v[0], y_v[0], s1_v[0], s0_v[0], fs_v[0]}, 16'd0);
    check("async_rst_cnt", 0, {8'd0, cnt_v[0]}, 16'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(0, 1'b1, 4'b1111, 4'b1111);
    @(posedge clk); #2;
    en_v[0] = 1'b0;
    check("post_rst_launch", 0, {11'd0, vld_v[0], y_v[0], s1_v[0], s0_v[0], fs_v[0]}, 16'b1_1001);
    check("post_rst_cnt", 0, {8'd0, cnt_v[0]}, 16'd1);
    repeat (20) @(posedge clk);
    #2;

    for (int s = 0; s < 2; s++) check("queue_drained", s, 16'(exp_q[s].size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
